// File: rtl/rs_operand_fetch_pkg.sv
// Shared definitions for the RS operand-fetch block: FSM encoding, the x0
// register constant and the default RS tag width.
package rs_operand_fetch_pkg;

    localparam int unsigned RS_WIDTH_DEFAULT = 2;
    localparam logic [4:0]  REG_ZERO         = 5'd0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } state_e;

    // An operand needs the register file only when enabled and not x0.
    function automatic logic operand_live(input logic en, input logic [4:0] rs);
        return en && (rs != REG_ZERO);
    endfunction

endpackage

// File: rtl/rs_operand_fetch_if.sv
// Issue, register-file request/response, ROB snoop and result signals of the
// operand-fetch block; master is the surrounding pipeline, slave the block.
interface rs_operand_fetch_if
    import rs_operand_fetch_pkg::*;
#(
    parameter int unsigned RS_WIDTH = RS_WIDTH_DEFAULT
);
    logic                issue_valid;
    logic                issue_ready;
    logic [RS_WIDTH-1:0] issue_index;
    logic                issue_rs1_en;
    logic [4:0]          issue_rs1;
    logic                issue_rs2_en;
    logic [4:0]          issue_rs2;

    logic                to_rf_rs1_flag;
    logic                to_rf_rs2_flag;
    logic [4:0]          to_rf_rs1;
    logic [4:0]          to_rf_rs2;
    logic [RS_WIDTH-1:0] to_rf_index;

    logic                from_rf_rs1_flag;
    logic                from_rf_rs2_flag;
    logic [RS_WIDTH-1:0] from_rf_index;
    logic [31:0]         from_rf_rs1;
    logic [31:0]         from_rf_rs2;

    logic                snoop_rob;
    logic [4:0]          snoop_rob_rd;
    logic [31:0]         snoop_rob_wdata;

    logic                out_valid;
    logic [RS_WIDTH-1:0] out_index;
    logic [31:0]         out_rs1_val;
    logic [31:0]         out_rs2_val;

    modport master (
        output issue_valid, issue_index, issue_rs1_en, issue_rs1, issue_rs2_en, issue_rs2,
        output from_rf_rs1_flag, from_rf_rs2_flag, from_rf_index, from_rf_rs1, from_rf_rs2,
        output snoop_rob, snoop_rob_rd, snoop_rob_wdata,
        input  issue_ready,
        input  to_rf_rs1_flag, to_rf_rs2_flag, to_rf_rs1, to_rf_rs2, to_rf_index,
        input  out_valid, out_index, out_rs1_val, out_rs2_val
    );

    modport slave (
        input  issue_valid, issue_index, issue_rs1_en, issue_rs1, issue_rs2_en, issue_rs2,
        input  from_rf_rs1_flag, from_rf_rs2_flag, from_rf_index, from_rf_rs1, from_rf_rs2,
        input  snoop_rob, snoop_rob_rd, snoop_rob_wdata,
        output issue_ready,
        output to_rf_rs1_flag, to_rf_rs2_flag, to_rf_rs1, to_rf_rs2, to_rf_index,
        output out_valid, out_index, out_rs1_val, out_rs2_val
    );

endinterface

// File: rtl/rs_operand_slot.sv
// One operand of an RS fetch: latches the register number, captures the
// tagged register-file response and keeps the newest ROB bypass value.
module rs_operand_slot
    import rs_operand_fetch_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        start,
    input  logic        start_en,
    input  logic [4:0]  start_rs,
    input  logic        snoop_win,
    input  logic        capture_win,
    input  logic        snoop_rob,
    input  logic [4:0]  snoop_rob_rd,
    input  logic [31:0] snoop_rob_wdata,
    input  logic        rf_flag,
    input  logic        rf_tag_match,
    input  logic [31:0] rf_data,
    output logic [4:0]  rs,
    output logic        resolved,
    output logic [31:0] value
);

    logic        en_q;
    logic [4:0]  rs_q;
    logic        got_q;
    logic [31:0] data_q;
    logic        hit_q;
    logic [31:0] bypass_q;

    logic live;
    logic hit_now;
    logic cap_now;

    assign live     = operand_live(en_q, rs_q);
    assign hit_now  = snoop_win && snoop_rob && (snoop_rob_rd == rs_q) && live;
    assign cap_now  = capture_win && rf_flag && rf_tag_match && live;
    assign resolved = !live || got_q || cap_now;
    assign rs       = rs_q;

    // Bypass beats register-file data, including a capture in the same cycle.
    always_comb begin
        value = 32'd0;
        if (live) begin
            if (hit_now) begin
                value = snoop_rob_wdata;
            end else if (hit_q) begin
                value = bypass_q;
            end else if (cap_now) begin
                value = rf_data;
            end else begin
                value = data_q;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            en_q     <= 1'b0;
            rs_q     <= REG_ZERO;
            got_q    <= 1'b0;
            data_q   <= 32'd0;
            hit_q    <= 1'b0;
            bypass_q <= 32'd0;
        end else if (rdy_in) begin
            if (start) begin
                en_q     <= start_en;
                rs_q     <= start_rs;
                got_q    <= 1'b0;
                data_q   <= 32'd0;
                hit_q    <= 1'b0;
                bypass_q <= 32'd0;
            end else begin
                if (hit_now) begin
                    hit_q    <= 1'b1;
                    bypass_q <= snoop_rob_wdata;
                end
                if (cap_now) begin
                    got_q  <= 1'b1;
                    data_q <= rf_data;
                end
            end
        end
    end

endmodule

// File: rtl/rs_operand_fetch.sv
// Requester side of the register-file read port: issues one rs1/rs2 fetch per
// RS entry, merges tagged responses with ROB bypass and returns both operands.
module rs_operand_fetch
    import rs_operand_fetch_pkg::*;
#(
    parameter int unsigned RS_WIDTH = RS_WIDTH_DEFAULT
) (
    input logic               clk_in,
    input logic               rst_in,
    input logic               rdy_in,
    rs_operand_fetch_if.slave bus
);

    state_e state_q, state_d;
    logic   accept;
    logic   done;

    logic [RS_WIDTH-1:0] index_q;
    logic                rs1_flag_q;
    logic                rs2_flag_q;
    logic                out_valid_q;
    logic [RS_WIDTH-1:0] out_index_q;
    logic [31:0]         out_rs1_q;
    logic [31:0]         out_rs2_q;

    logic        snoop_win;
    logic        capture_win;
    logic        tag_match;
    logic        rs1_resolved;
    logic        rs2_resolved;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [4:0]  rs1_num;
    logic [4:0]  rs2_num;

    // Snoops in the accept cycle are already visible in the register file.
    assign snoop_win   = (state_q == StReq) || (state_q == StWait);
    assign capture_win = (state_q == StWait);
    assign tag_match   = (bus.from_rf_index == index_q);

    rs_operand_slot u_rs1 (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .start           (accept),
        .start_en        (bus.issue_rs1_en),
        .start_rs        (bus.issue_rs1),
        .snoop_win       (snoop_win),
        .capture_win     (capture_win),
        .snoop_rob       (bus.snoop_rob),
        .snoop_rob_rd    (bus.snoop_rob_rd),
        .snoop_rob_wdata (bus.snoop_rob_wdata),
        .rf_flag         (bus.from_rf_rs1_flag),
        .rf_tag_match    (tag_match),
        .rf_data         (bus.from_rf_rs1),
        .rs              (rs1_num),
        .resolved        (rs1_resolved),
        .value           (rs1_value)
    );

    rs_operand_slot u_rs2 (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .start           (accept),
        .start_en        (bus.issue_rs2_en),
        .start_rs        (bus.issue_rs2),
        .snoop_win       (snoop_win),
        .capture_win     (capture_win),
        .snoop_rob       (bus.snoop_rob),
        .snoop_rob_rd    (bus.snoop_rob_rd),
        .snoop_rob_wdata (bus.snoop_rob_wdata),
        .rf_flag         (bus.from_rf_rs2_flag),
        .rf_tag_match    (tag_match),
        .rf_data         (bus.from_rf_rs2),
        .rs              (rs2_num),
        .resolved        (rs2_resolved),
        .value           (rs2_value)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        done    = 1'b0;
        if (rdy_in) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.issue_valid) begin
                        accept  = 1'b1;
                        state_d = StReq;
                    end
                end
                StReq:  state_d = StWait;
                StWait: begin
                    if (rs1_resolved && rs2_resolved) begin
                        done    = 1'b1;
                        state_d = StDone;
                    end
                end
                StDone: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= StIdle;
            index_q     <= '0;
            rs1_flag_q  <= 1'b0;
            rs2_flag_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_rs1_q   <= 32'd0;
            out_rs2_q   <= 32'd0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            out_valid_q <= done;
            if (accept) begin
                index_q    <= bus.issue_index;
                rs1_flag_q <= operand_live(bus.issue_rs1_en, bus.issue_rs1);
                rs2_flag_q <= operand_live(bus.issue_rs2_en, bus.issue_rs2);
            end else if (state_q == StReq) begin
                rs1_flag_q <= 1'b0;
                rs2_flag_q <= 1'b0;
            end
            if (done) begin
                out_index_q <= index_q;
                out_rs1_q   <= rs1_value;
                out_rs2_q   <= rs2_value;
            end
        end
    end

    // Ready is held low while reset is applied, even though the state is IDLE.
    assign bus.issue_ready    = (state_q == StIdle) && !rst_in;
    assign bus.to_rf_rs1_flag = rs1_flag_q;
    assign bus.to_rf_rs2_flag = rs2_flag_q;
    assign bus.to_rf_rs1      = rs1_num;
    assign bus.to_rf_rs2      = rs2_num;
    assign bus.to_rf_index    = index_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_index      = out_index_q;
    assign bus.out_rs1_val    = out_rs1_q;
    assign bus.out_rs2_val    = out_rs2_q;

endmodule

// File: tb/tb_rs_operand_fetch.sv
// Bench for rs_operand_fetch: the bench plays register file and ROB, and
// predicts each operand from a register array plus the newest in-window snoop.
module tb_rs_operand_fetch;

    localparam int unsigned RSW = 2;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    always #5 clk_in = ~clk_in;

    rs_operand_fetch_if #(.RS_WIDTH(RSW)) bus ();

    rs_operand_fetch #(.RS_WIDTH(RSW)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    typedef struct packed {
        logic [1:0]  idx;
        logic        en1;
        logic [4:0]  rs1;
        logic        en2;
        logic [4:0]  rs2;
        int          d1;
        int          d2;
        logic        bogus;
        int          stalls;
        int          req_stall;
        logic        si_v;
        logic [4:0]  si_rd;
        logic [31:0] si_d;
        logic        sr_v;
        logic [4:0]  sr_rd;
        logic [31:0] sr_d;
        logic        sw_v;
        logic [4:0]  sw_rd;
        logic [31:0] sw_d;
        int          sw_at;
    } txn_t;

    logic [31:0] rf [32];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic quiet_bus();
        bus.issue_valid      = 1'b0;
        bus.from_rf_rs1_flag = 1'b0;
        bus.from_rf_rs2_flag = 1'b0;
        bus.snoop_rob        = 1'b0;
    endtask

    // Expects to be entered at a negedge with the DUT idle.
    task automatic run(input txn_t t);
        logic        f1, f2, h1, h2, sw_ok, sw_now, seen;
        logic [31:0] hv1, hv2, snap1, snap2, e1, e2;
        int          r1, r2, w_last, w, stall_left, c;

        f1 = t.en1 && (t.rs1 != 5'd0);
        f2 = t.en2 && (t.rs2 != 5'd0);
        r1 = t.bogus && t.d1 < 1 ? 1 : t.d1;
        r2 = t.bogus && t.d2 < 1 ? 1 : t.d2;
        w_last = 0;
        if (f1 && r1 > w_last) w_last = r1;
        if (f2 && r2 > w_last) w_last = r2;
        sw_ok = t.sw_v && (t.sw_at <= w_last);

        // Newest matching snoop in the REQ/WAIT window wins.
        h1 = 1'b0; h2 = 1'b0; hv1 = 32'd0; hv2 = 32'd0;
        if (t.sr_v && t.sr_rd == t.rs1) begin h1 = 1'b1; hv1 = t.sr_d; end
        if (t.sr_v && t.sr_rd == t.rs2) begin h2 = 1'b1; hv2 = t.sr_d; end
        if (sw_ok && t.sw_rd == t.rs1) begin h1 = 1'b1; hv1 = t.sw_d; end
        if (sw_ok && t.sw_rd == t.rs2) begin h2 = 1'b1; hv2 = t.sw_d; end

        check("idle_ready", bus.issue_ready, 1'b1);
        bus.issue_valid  = 1'b1;
        bus.issue_index  = t.idx;
        bus.issue_rs1_en = t.en1;
        bus.issue_rs1    = t.rs1;
        bus.issue_rs2_en = t.en2;
        bus.issue_rs2    = t.rs2;
        bus.snoop_rob       = t.si_v;
        bus.snoop_rob_rd    = t.si_rd;
        bus.snoop_rob_wdata = t.si_d;
        @(posedge clk_in);
        if (t.si_v) rf[t.si_rd] = t.si_d;
        snap1 = rf[t.rs1];
        snap2 = rf[t.rs2];
        e1 = !f1 ? 32'd0 : (h1 ? hv1 : snap1);
        e2 = !f2 ? 32'd0 : (h2 ? hv2 : snap2);

        @(negedge clk_in);
        quiet_bus();
        check("req_ready", bus.issue_ready, 1'b0);
        check("req_flag1", bus.to_rf_rs1_flag, f1);
        check("req_flag2", bus.to_rf_rs2_flag, f2);
        check("req_rs1", bus.to_rf_rs1, t.rs1);
        check("req_rs2", bus.to_rf_rs2, t.rs2);
        check("req_index", bus.to_rf_index, t.idx);
        check("req_out_valid", bus.out_valid, 1'b0);
        for (int s = 0; s < t.req_stall; s++) begin
            rdy_in = 1'b0;
            @(posedge clk_in);
            @(negedge clk_in);
            check("req_frozen_flags", {bus.to_rf_rs1_flag, bus.to_rf_rs2_flag}, {f1, f2});
        end
        rdy_in = 1'b1;
        bus.snoop_rob       = t.sr_v;
        bus.snoop_rob_rd    = t.sr_rd;
        bus.snoop_rob_wdata = t.sr_d;
        @(posedge clk_in);
        if (t.sr_v) rf[t.sr_rd] = t.sr_d;

        w = 0; stall_left = t.stalls; c = 0; seen = 1'b0;
        while (!seen && c < 40) begin
            @(negedge clk_in);
            quiet_bus();
            rdy_in = 1'b1;
            sw_now = 1'b0;
            if (bus.out_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                check("wait_idle_outs",
                      {bus.to_rf_rs1_flag, bus.to_rf_rs2_flag, bus.issue_ready}, 3'b000);
                if (stall_left > 0) begin
                    rdy_in = 1'b0;
                    stall_left--;
                end else begin
                    if (t.bogus && w == 0) begin
                        bus.from_rf_index    = t.idx ^ 2'b01;
                        bus.from_rf_rs1_flag = 1'b1;
                        bus.from_rf_rs2_flag = 1'b1;
                        bus.from_rf_rs1      = 32'hBAD0_BAD0;
                        bus.from_rf_rs2      = 32'hBAD1_BAD1;
                    end else begin
                        bus.from_rf_index = t.idx;
                        if (f1 && w == r1) begin
                            bus.from_rf_rs1_flag = 1'b1;
                            bus.from_rf_rs1      = snap1;
                        end
                        if (f2 && w == r2) begin
                            bus.from_rf_rs2_flag = 1'b1;
                            bus.from_rf_rs2      = snap2;
                        end
                    end
                    if (sw_ok && w == t.sw_at) begin
                        bus.snoop_rob       = 1'b1;
                        bus.snoop_rob_rd    = t.sw_rd;
                        bus.snoop_rob_wdata = t.sw_d;
                        sw_now = 1'b1;
                    end
                    w++;
                end
                @(posedge clk_in);
                if (sw_now) rf[t.sw_rd] = t.sw_d;
                c++;
            end
        end
        check("out_seen", seen, 1'b1);
        if (seen) begin
            check("latency", c, w_last + 1 + t.stalls);
            check("out_index", bus.out_index, t.idx);
            check("out_rs1", bus.out_rs1_val, e1);
            check("out_rs2", bus.out_rs2_val, e2);
            check("done_ready", bus.issue_ready, 1'b0);
            @(posedge clk_in);
            @(negedge clk_in);
            check("pulse_end", bus.out_valid, 1'b0);
            check("ready_again", bus.issue_ready, 1'b1);
        end
    endtask

    initial begin
        txn_t t;
        quiet_bus();
        bus.issue_index = '0; bus.issue_rs1_en = 1'b0; bus.issue_rs1 = '0;
        bus.issue_rs2_en = 1'b0; bus.issue_rs2 = '0; bus.from_rf_index = '0;
        bus.from_rf_rs1 = '0; bus.from_rf_rs2 = '0; bus.snoop_rob_rd = '0;
        bus.snoop_rob_wdata = '0;
        rst_in = 1'b1;
        rdy_in = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'hDEAD; rf[5] = 32'h11; rf[6] = 32'h22; rf[7] = 32'h1;

        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_ready", bus.issue_ready, 1'b0);
        check("rst_outs", {bus.out_valid, bus.to_rf_rs1_flag, bus.to_rf_rs2_flag}, 3'b000);
        check("rst_vals", bus.out_rs1_val | bus.out_rs2_val, 32'd0);
        rst_in = 1'b0;
        rdy_in = 1'b1;
        @(negedge clk_in);
        check("ready_after_reset", bus.issue_ready, 1'b1);

        // Nominal fetch
        t = '0; t.idx = 2'd2; t.en1 = 1'b1; t.rs1 = 5'd5; t.en2 = 1'b1; t.rs2 = 5'd6;
        run(t);
        // x0 with garbage and a disabled operand
        t = '0; t.idx = 2'd1; t.en1 = 1'b1; t.rs1 = 5'd0; t.en2 = 1'b0; t.rs2 = 5'd3;
        run(t);
        // Bypass during REQ
        t = '0; t.idx = 2'd3; t.en1 = 1'b1; t.rs1 = 5'd7;
        t.sr_v = 1'b1; t.sr_rd = 5'd7; t.sr_d = 32'h99;
        run(t);
        // Bypass during WAIT, same cycle as the register-file response
        rf[7] = 32'h1;
        t = '0; t.idx = 2'd0; t.en1 = 1'b1; t.rs1 = 5'd7;
        t.sw_v = 1'b1; t.sw_rd = 5'd7; t.sw_d = 32'h99;
        run(t);
        // Two bypasses, newest wins
        rf[7] = 32'h1;
        t = '0; t.idx = 2'd1; t.en1 = 1'b1; t.rs1 = 5'd7;
        t.sr_v = 1'b1; t.sr_rd = 5'd7; t.sr_d = 32'h10;
        t.sw_v = 1'b1; t.sw_rd = 5'd7; t.sw_d = 32'h20;
        run(t);
        // rs1 == rs2 with one snoop
        t = '0; t.idx = 2'd2; t.en1 = 1'b1; t.rs1 = 5'd9; t.en2 = 1'b1; t.rs2 = 5'd9;
        t.sr_v = 1'b1; t.sr_rd = 5'd9; t.sr_d = 32'h5A;
        run(t);
        // Staggered responses, then a mismatched tag ahead of both
        t = '0; t.idx = 2'd3; t.en1 = 1'b1; t.rs1 = 5'd5; t.en2 = 1'b1; t.rs2 = 5'd6;
        t.d1 = 0; t.d2 = 1;
        run(t);
        t.bogus = 1'b1; t.d2 = 2;
        run(t);
        // rdy_in low for three WAIT cycles and two REQ cycles
        t = '0; t.idx = 2'd1; t.en1 = 1'b1; t.rs1 = 5'd5; t.en2 = 1'b1; t.rs2 = 5'd6;
        t.stalls = 3;
        run(t);
        t.stalls = 0; t.req_stall = 2; t.sr_v = 1'b1; t.sr_rd = 5'd6; t.sr_d = 32'h66;
        run(t);
        // Accept-cycle snoop reaches the operand through the register file
        t = '0; t.idx = 2'd0; t.en1 = 1'b1; t.rs1 = 5'd5;
        t.si_v = 1'b1; t.si_rd = 5'd5; t.si_d = 32'h77;
        run(t);

        for (int n = 0; n < 60; n++) begin
            t = '0;
            t.idx = 2'($urandom);
            t.en1 = 1'($urandom); t.rs1 = 5'($urandom_range(0, 12));
            t.en2 = 1'($urandom); t.rs2 = 5'($urandom_range(0, 12));
            t.d1 = $urandom_range(0, 2); t.d2 = $urandom_range(0, 2);
            t.bogus = ($urandom_range(0, 3) == 0);
            t.stalls = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            t.req_stall = ($urandom_range(0, 4) == 0) ? 1 : 0;
            t.si_v = 1'($urandom); t.si_rd = $urandom_range(0, 1) ? t.rs1 : t.rs2;
            t.si_d = $urandom;
            t.sr_v = 1'($urandom); t.sr_rd = $urandom_range(0, 1) ? t.rs1 : 5'($urandom);
            t.sr_d = $urandom;
            t.sw_v = 1'($urandom); t.sw_rd = $urandom_range(0, 1) ? t.rs2 : t.rs1;
            t.sw_d = $urandom; t.sw_at = $urandom_range(0, 2);
            run(t);
        end

        // Reset during REQ aborts the fetch; a late response is ignored
        bus.issue_valid = 1'b1; bus.issue_index = 2'd1;
        bus.issue_rs1_en = 1'b1; bus.issue_rs1 = 5'd5;
        bus.issue_rs2_en = 1'b0; bus.issue_rs2 = 5'd0;
        @(posedge clk_in);
        @(negedge clk_in);
        quiet_bus();
        check("abort_req_flag", bus.to_rf_rs1_flag, 1'b1);
        rst_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        check("abort_ready_in_reset", bus.issue_ready, 1'b0);
        check("abort_outs", {bus.to_rf_rs1_flag, bus.to_rf_rs2_flag, bus.out_valid}, 3'b000);
        check("abort_vals", bus.out_rs1_val | bus.out_rs2_val, 32'd0);
        check("abort_index", {bus.to_rf_index, bus.out_index}, 4'd0);
        rst_in = 1'b0;
        bus.from_rf_index = 2'd1; bus.from_rf_rs1_flag = 1'b1; bus.from_rf_rs1 = 32'h11;
        @(posedge clk_in);
        @(negedge clk_in);
        quiet_bus();
        check("abort_ready_after", bus.issue_ready, 1'b1);
        check("abort_no_result", bus.out_valid, 1'b0);
        @(posedge clk_in);
        @(negedge clk_in);
        check("abort_still_idle", {bus.out_valid, bus.issue_ready}, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
